// File: rtl/program_loader.sv
// program_loader: front-end for the SAP-1 programming port.
//
// Accepts a framed byte stream (LEN, LEN payload bytes, CSUM) over a valid/ready handshake,
// writes payload byte k into CPU RAM address k, and holds the CPU in reset until the
// checksum (payload sum + CSUM == 0 mod 256) verifies.
//
// Ports:
//   clk, rst           rising-edge clock, synchronous active-high reset
//   start              begin a new load (honoured in IDLE, RUN and ERROR only)
//   in_valid, in_data  byte source; transfer when in_valid && in_ready
//   in_ready           loader can accept a byte
//   pr_mode            CPU programming mode, high from LEN through CSUM
//   pr_address/pr_data RAM write address/data, held until the next payload byte
//   pr_we              one-cycle RAM write strobe
//   cpu_rst            CPU reset, low only in RUN
//   done               load verified, CPU running
//   error              bad length or checksum, sticky until start or rst
//
// All outputs are registered: the output process decodes the *next* state, so each output
// reflects the state the FSM is in during the same cycle.

module program_loader #(
  parameter int unsigned RAM_DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       pr_mode,
  output logic [3:0] pr_address,
  output logic [7:0] pr_data,
  output logic       pr_we,
  output logic       cpu_rst,
  output logic       done,
  output logic       error
);

  typedef enum logic [2:0] {
    StIdle,
    StLen,
    StData,
    StWrite,
    StCsum,
    StRun,
    StError
  } state_e;

  localparam logic [7:0] MaxLen = 8'(RAM_DEPTH);

  state_e     state_q, state_d;
  logic [4:0] len_q, len_d;
  logic [3:0] idx_q, idx_d;
  logic [7:0] sum_q, sum_d;
  logic [3:0] addr_d;
  logic [7:0] data_d;

  logic in_ready_d, pr_mode_d, pr_we_d, cpu_rst_d, done_d, error_d;

  logic       xfer;
  logic [7:0] csum_total;

  assign xfer       = in_valid && in_ready;
  assign csum_total = sum_q + in_data;

  // State and datapath register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      len_q      <= '0;
      idx_q      <= '0;
      sum_q      <= '0;
      pr_address <= '0;
      pr_data    <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      sum_q      <= sum_d;
      pr_address <= addr_d;
      pr_data    <= data_d;
    end
  end

  // Next-state and datapath logic.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    addr_d  = pr_address;
    data_d  = pr_data;
    unique case (state_q)
      StIdle, StRun, StError: begin
        if (start) state_d = StLen;
      end
      StLen: begin
        if (xfer) begin
          if (in_data == 8'd0 || in_data > MaxLen) begin
            state_d = StError;
          end else begin
            len_d   = in_data[4:0];
            idx_d   = '0;
            sum_d   = '0;
            state_d = StData;
          end
        end
      end
      StData: begin
        if (xfer) begin
          data_d  = in_data;
          addr_d  = idx_q;
          sum_d   = sum_q + in_data;
          state_d = StWrite;
        end
      end
      StWrite: begin
        // Compare before incrementing so idx never wraps on a full-depth frame.
        if ({1'b0, idx_q} == len_q - 5'd1) begin
          state_d = StCsum;
        end else begin
          idx_d   = idx_q + 4'd1;
          state_d = StData;
        end
      end
      StCsum: begin
        if (xfer) state_d = (csum_total == 8'd0) ? StRun : StError;
      end
      default: state_d = StIdle;
    endcase
  end

  // Output decode from the next state, registered below.
  always_comb begin
    in_ready_d = 1'b0;
    pr_mode_d  = 1'b0;
    pr_we_d    = 1'b0;
    cpu_rst_d  = 1'b1;
    done_d     = 1'b0;
    error_d    = 1'b0;
    unique case (state_d)
      StIdle: ;
      StLen, StData, StCsum: begin
        in_ready_d = 1'b1;
        pr_mode_d  = 1'b1;
      end
      StWrite: begin
        pr_mode_d = 1'b1;
        pr_we_d   = 1'b1;
      end
      StRun: begin
        cpu_rst_d = 1'b0;
        done_d    = 1'b1;
      end
      StError: error_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready <= 1'b0;
      pr_mode  <= 1'b0;
      pr_we    <= 1'b0;
      cpu_rst  <= 1'b1;
      done     <= 1'b0;
      error    <= 1'b0;
    end else begin
      in_ready <= in_ready_d;
      pr_mode  <= pr_mode_d;
      pr_we    <= pr_we_d;
      cpu_rst  <= cpu_rst_d;
      done     <= done_d;
      error    <= error_d;
    end
  end

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready, pr_mode, pr_we, cpu_rst, done, error;
  logic [3:0] pr_address;
  logic [7:0] pr_data;

  program_loader #(.RAM_DEPTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .pr_mode   (pr_mode),
    .pr_address(pr_address),
    .pr_data   (pr_data),
    .pr_we     (pr_we),
    .cpu_rst   (cpu_rst),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  logic [11:0] exp_wr[$];   // {addr, data} of each expected RAM write
  int          exp_out[$];  // 1 = done, 2 = error
  bit          mon_en = 1'b0;
  logic        done_p = 1'b0;
  logic        error_p = 1'b0;
  logic [7:0]  pl[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT strobes a write or reaches an outcome.
  always @(negedge clk) begin
    logic [11:0] w;
    int          e;
    if (mon_en) begin
      if (pr_we) begin
        if (exp_wr.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL unexpected_write: addr %0d data %0h, no write expected",
                   pr_address, pr_data);
        end else begin
          w = exp_wr.pop_front();
          check("write_addr_data", {20'd0, pr_address, pr_data}, {20'd0, w});
          check("ready_low_during_we", in_ready, 0);
        end
      end
      if ((done && !done_p) || (error && !error_p)) begin
        if (exp_out.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL unexpected_outcome: done %0b error %0b, none expected", done, error);
        end else begin
          e = exp_out.pop_front();
          check("outcome", {30'd0, error, done}, e);
        end
      end
      check("cpu_rst_guard", cpu_rst || (!pr_mode && !pr_we), 1);
    end
    done_p  <= done;
    error_p <= error;
  end

  // Offer one byte; returns #1 after the accepting edge with in_valid low.
  task automatic send(input logic [7:0] b, input bit bp);
    int waited = 0;
    bit fin = 1'b0;
    if (bp) begin
      repeat ($urandom_range(0, 2)) begin
        in_data = 8'($urandom);
        @(posedge clk);
        #1;
      end
    end
    in_valid = 1'b1;
    in_data  = b;
    while (!fin) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        fin = 1'b1;
      end else begin
        @(posedge clk);
        #1;
        waited++;
        if (waited > 100) begin
          n_vec++;
          n_miss++;
          $display("FAIL send_timeout: byte %0h, in_ready %0b, expected 1", b, in_ready);
          fin = 1'b1;
        end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic start_load();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("start_pr_mode", pr_mode, 1);
    check("start_in_ready", in_ready, 1);
    check("start_cpu_rst", cpu_rst, 1);
    check("start_done", done, 0);
    check("start_error", error, 0);
  endtask

  task automatic load_frame(input logic [7:0] len, input int n, input logic [7:0] csum,
                            input int outcome, input bit bp, input bit noise);
    send(len, bp);
    for (int i = 0; i < n; i++) begin
      if (noise) start = 1'($urandom_range(0, 1));
      exp_wr.push_back({4'(i), pl[i]});
      send(pl[i], bp);
    end
    start = 1'b0;
    exp_out.push_back(outcome);
    send(csum, bp);
    check("frame_done", done, outcome == 1);
    check("frame_error", error, outcome == 2);
    check("frame_cpu_rst", cpu_rst, outcome != 1);
    check("frame_pr_mode", pr_mode, 0);
  endtask

  task automatic bad_len(input logic [7:0] len);
    exp_out.push_back(2);
    send(len, 1'b0);
    check("badlen_error", error, 1);
    check("badlen_cpu_rst", cpu_rst, 1);
    check("badlen_done", done, 0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_pr_mode"}, pr_mode, 0);
    check({tag, "_pr_address"}, pr_address, 0);
    check({tag, "_pr_data"}, pr_data, 0);
    check({tag, "_pr_we"}, pr_we, 0);
    check({tag, "_cpu_rst"}, cpu_rst, 1);
    check({tag, "_done"}, done, 0);
    check({tag, "_error"}, error, 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_vals("reset");
    mon_en = 1'b1;

    // Nominal load: 1E + 2F + E0 + D3 = 0x200.
    pl[0] = 8'h1E; pl[1] = 8'h2F; pl[2] = 8'hE0;
    start_load();
    load_frame(8'h03, 3, 8'hD3, 1, 1'b0, 1'b0);

    // Bad checksum, then start clears error.
    start_load();
    load_frame(8'h03, 3, 8'hD4, 2, 1'b0, 1'b0);
    start_load();

    // Bad lengths: 0 and 17.
    bad_len(8'h00);
    start_load();
    bad_len(8'h11);

    // Full RAM with backpressure: sum 00..0F = 0x78, + 0x88 = 0x100.
    for (int i = 0; i < 16; i++) pl[i] = 8'(i);
    start_load();
    load_frame(8'h10, 16, 8'h88, 1, 1'b1, 1'b0);

    // Reset after the second payload byte.
    pl[0] = 8'h1E; pl[1] = 8'h2F; pl[2] = 8'hE0;
    start_load();
    send(8'h03, 1'b0);
    exp_wr.push_back({4'd0, 8'h1E});
    send(8'h1E, 1'b0);
    exp_wr.push_back({4'd1, 8'h2F});
    send(8'h2F, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_reset_vals("midrst");
    rst = 1'b0;
    start_load();
    load_frame(8'h03, 3, 8'hD3, 1, 1'b0, 1'b0);

    // Reload from RUN with start noise mid-frame: 1+2+3+4 = 0x0A, + F6 = 0x100.
    pl[0] = 8'h01; pl[1] = 8'h02; pl[2] = 8'h03; pl[3] = 8'h04;
    start_load();
    load_frame(8'h04, 4, 8'hF6, 1, 1'b1, 1'b1);

    // Second reload overwrites: 55 + AA = FF, + 01 = 0x100.
    pl[0] = 8'h55; pl[1] = 8'hAA;
    start_load();
    load_frame(8'h02, 2, 8'h01, 1, 1'b0, 1'b0);

    repeat (5) @(posedge clk);
    #1;
    check("writes_drained", exp_wr.size(), 0);
    check("outcomes_drained", exp_out.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
